uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 47 ++++
 rtl/uart_rx_param.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the parity-mode constants and the receiver state encoding so that
// every UART block agrees on them.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_START      = 3'd1,
      ST_DATA       = 3'd2,
      ST_PARITY     = 3'd3,
      ST_STOP       = 3'd4,
      ST_CLEANUP    = 3'd5,
      ST_BREAK_WAIT = 3'd6
   } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
// Ports:
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   i_Rx_Async       : raw serial line
//   i_Sample         : capture the current synchronized value as a vote
//   o_Rx             : synchronized line (2-flop)
//   o_Vote           : 2-of-3 majority of the two captured votes and the
//                      current synchronized value
module uart_rx_sync (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Rx_Async,
   input  logic i_Sample,
   output logic o_Rx,
   output logic o_Vote
);
   import uart_pkg::*;

   logic       meta_q, meta_d;
   logic       sync_q, sync_d;
   logic [1:0] samp_q, samp_d;

   always_comb begin
      meta_d = i_Rx_Async;
      sync_d = meta_q;
      samp_d = samp_q;
      if (i_Sample) samp_d = {samp_q[0], sync_q};
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         samp_q <= 2'b11;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         samp_q <= samp_d;
      end
   end

   assign o_Rx = sync_q;
   // The third vote is the live sample, so the result is valid in the same
   // cycle as the last sample point.
   assign o_Vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & sync_q) | (samp_q[0] & sync_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterized UART receiver with majority-vote bit sampling, optional
// parity, 1 or 2 checked stop bits and break handling after a framing error.
// Ports:
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   i_Rx_Serial      : asynchronous serial line, idle high
//   o_Rx_DV          : one-cycle pulse, frame complete
//   o_Rx_Byte        : received data (LSB first on the line)
//   o_Parity_Err     : parity mismatch of the flagged frame
//   o_Frame_Err      : a stop bit of the flagged frame was low
//   o_Busy           : receiver not idle
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Rx_Serial,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Busy
);
   import uart_pkg::*;

   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int IW  = $clog2(DATA_BITS);
   localparam int MID = (CLKS_PER_BIT - 1) / 2;

   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(MID);
   localparam logic [CW-1:0] CNT_VOTE = CW'(MID + 1);

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 dv_q, dv_d;
   logic [DATA_BITS-1:0] byte_q, byte_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;

   logic rx, vote, sample, at_end, at_vote, par_x;

   uart_rx_sync u_sync (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .i_Rx_Async (i_Rx_Serial),
      .i_Sample   (sample),
      .o_Rx       (rx),
      .o_Vote     (vote)
   );

   assign at_end  = (cnt_q == CNT_LAST);
   assign at_vote = (cnt_q == CNT_VOTE);
   assign par_x   = (^shift_q) ^ vote;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      dv_d       = 1'b0;
      byte_d     = byte_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      sample     = 1'b0;

      // Bit-period timing is shared by every state that samples the line.
      if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP}) begin
         cnt_d  = at_end ? '0 : cnt_q + CW'(1);
         sample = (cnt_q == CNT_S0) || (cnt_q == CNT_S1);
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            idx_d  = '0;
            stop_d = 1'b0;
            perr_d = 1'b0;
            ferr_d = 1'b0;
            if (!rx) state_d = ST_START;
         end
         ST_START: begin
            if (at_vote && vote) begin
               state_d = ST_IDLE;   // glitch, not a real start bit
               cnt_d   = '0;
            end else if (at_end) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
            if (at_end) begin
               if (idx_q == IW'(DATA_BITS - 1))
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               else
                  idx_d = idx_q + IW'(1);
            end
         end
         ST_PARITY: begin
            if (at_vote) perr_d = (PARITY == PARITY_ODD) ? ~par_x : par_x;
            if (at_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (at_vote && !vote) ferr_d = 1'b1;
            if (at_end) begin
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d    = ST_CLEANUP;
                  dv_d       = 1'b1;
                  byte_d     = shift_q;
                  perr_out_d = (PARITY == PARITY_NONE) ? 1'b0 : perr_q;
                  ferr_out_d = ferr_q;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         ST_CLEANUP: begin
            cnt_d   = '0;
            state_d = ferr_out_q ? ST_BREAK_WAIT : ST_IDLE;
         end
         ST_BREAK_WAIT: begin
            // A low line after a framing error is a break, not a start bit.
            cnt_d = '0;
            if (rx) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         dv_q       <= 1'b0;
         byte_q     <= '0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         dv_q       <= dv_d;
         byte_q     <= byte_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
      end
   end

   assign o_Rx_DV      = dv_q;
   assign o_Rx_Byte    = byte_q;
   assign o_Parity_Err = perr_out_q;
   assign o_Frame_Err  = ferr_out_q;
   assign o_Busy       = (state_q != ST_IDLE);

endmodule
